uart_tx_serializer: RTL
=======================

# uart_tx_serializer

UART transmit serializer that consumes the per-bit strobe of the bit-rate tick generator and shifts out one asynchronous serial frame per accepted byte. It sits directly downstream of the bit-rate generator, with its `bit_en_i` input tied to the generator's `bit_en`. Upstream logic delivers parallel words through a valid/ready handshake. Frame format is start bit, DATA_W data bits LSB first, optional parity, then 1 or 2 stop bits.

## Interface
- DLY, 1, simulation delay on register assignments
- DATA_W, 8, data bits per frame; legal 5..9
- PARITY_EN, 0, 1 inserts a parity bit after the data bits
- PARITY_ODD, 0, 0 selects even parity, 1 selects odd; ignored when PARITY_EN=0
- STOP_BITS, 1, stop bits per frame; legal 1 or 2

- clk_i  input  1  single clock for all logic
- rst_i  input  1  synchronous, active-high reset
- bit_en_i  input  1  one-cycle bit-boundary strobe from the bit-rate generator
- tx_data_i  input  DATA_W  word to transmit
- tx_valid_i  input  1  tx_data_i is valid
- tx_ready_o  output  1  block accepts tx_data_i this cycle
- tx_o  output  1  serial line, registered, idle high
- busy_o  output  1  frame in progress (state != IDLE)
- done_o  output  1  one-cycle pulse when the last stop bit ends

## Operation
- States: IDLE, ARM, START, DATA, PARITY, STOP.
- Handshake: a word is accepted when tx_valid_i && tx_ready_o at a rising edge. tx_data_i is latched into the shift register and the parity bit is latched at the same time. Input may change freely after acceptance.
- Parity: even is ^data; odd is ~^data.
- tx_ready_o is combinational and equals (state==IDLE) || (state==STOP && bit_en_i && last stop bit). It is forced to 0 while rst_i is high. It never depends on tx_valid_i.
- IDLE: tx_o=1. On acceptance go to ARM. A bit_en_i in the acceptance cycle is ignored.
- ARM: wait for bit_en_i. On bit_en_i, tx_o<=0 and go to START.
- START: on bit_en_i, tx_o<=data[0], bit_cnt<=0, go to DATA.
- DATA: on bit_en_i, if bit_cnt==DATA_W-1:
  - with PARITY_EN, tx_o<=parity and go to PARITY;
  - without PARITY_EN, tx_o<=1, stop_cnt<=0, go to STOP.
  - Otherwise shift right, tx_o<=next bit, bit_cnt++.
- PARITY: on bit_en_i, tx_o<=1, stop_cnt<=0, go to STOP.
- STOP: on bit_en_i:
  - if stop_cnt==STOP_BITS-1, pulse done_o. If a word is accepted in that same cycle, tx_o<=0 and go to START directly. Otherwise go to IDLE with tx_o held at 1.
  - If stop_cnt is not yet STOP_BITS-1, stop_cnt++.
- Counter widths: bit_cnt is clog2(DATA_W) bits; stop_cnt is 1 bit. Neither counter wraps past its terminal value.
- Outside the listed transitions, state, tx_o and counters hold while bit_en_i is low.

## Timing
- Reset, checked at each edge while rst_i=1: tx_o=1, busy_o=0, done_o=0, tx_ready_o=0, state=IDLE, counters=0.
- Reset mid-frame aborts the frame. tx_o returns to 1 at the next edge and no done_o is produced.
- Every frame bit lasts exactly the time between consecutive bit_en_i pulses, i.e. `period` cycles.
- Frame length is 1+DATA_W+PARITY_EN+STOP_BITS bit periods.
- Latency: tx_o falls one cycle after the first bit_en_i seen in ARM. With a free-running generator this is 2..period+1 cycles after acceptance.
- Back-to-back: a word accepted in the final stop-bit bit_en_i cycle starts its start bit immediately, with no idle gap.
- done_o rises one cycle after the final stop-bit bit_en_i edge and lasts one cycle.
- busy_o is high from the cycle after acceptance until IDLE is re-entered.
- bit_en_i held constantly high (period=1) is legal and gives one cycle per bit.
- Behaviour for bit_en_i with non-uniform spacing: each bit simply lasts until the next strobe.

## Test plan
- 8N1, period=4, send 0xA5: tx_o after the falling edge is 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. done_o pulses once and tx_ready_o returns to 1.
- PARITY_EN=1, even, send 0x07: parity bit is 1. With PARITY_ODD=1 and the same word, parity bit is 0. Frame is 11 bit periods.
- Two words presented back-to-back (0x55, then 0x0F, with tx_valid_i held): the second start bit begins on the bit_en_i that ends the first stop bit, with zero idle cycles.
- STOP_BITS=2, period=3: stop phase is 6 cycles high before done_o. A new word accepted only at the end of the second stop bit.
- rst_i asserted during DATA bit 4: next edge tx_o=1, busy_o=0, no done_o. After release, 0x3C transmits correctly.
- bit_en_i tied high, 8N1, send 0x81: 10-cycle frame 0,1,0,0,0,0,0,0,1,1. tx_ready_o is low throughout except in IDLE and in the final stop-bit cycle.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, DATA_W data bits LSB first, optional parity,
// 1 or 2 stop bits, paced by an external bit-rate strobe.
module uart_tx_serializer #(
  parameter int DLY        = 1,
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              bit_en_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic              tx_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int CNT_W = $clog2(DATA_W);

  if (DATA_W < 5 || DATA_W > 9 || STOP_BITS < 1 || STOP_BITS > 2 || DLY < 0) begin : g_bad_param
    $error("uart_tx_serializer: illegal parameter combination");
  end

  typedef enum logic [2:0] {IDLE, ARM, START, DATA, PARITY, STOP} state_t;

  state_t            state_q, state_d;
  logic              tx_q, tx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic              done_q, done_d;

  logic bit_last;
  logic stop_last;
  logic in_par;

  assign bit_last  = (bit_cnt_q == CNT_W'(DATA_W - 1));
  assign stop_last = (stop_cnt_q == 1'(STOP_BITS - 1));
  assign in_par    = (PARITY_ODD != 0) ? ~^tx_data_i : ^tx_data_i;

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    shift_d    = shift_q;
    par_d      = par_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    done_d     = 1'b0;
    tx_ready_o = 1'b0;

    case (state_q)
      IDLE: begin
        tx_ready_o = 1'b1;
        tx_d       = 1'b1;
        if (tx_valid_i) begin
          shift_d = tx_data_i;
          par_d   = in_par;
          state_d = ARM;
        end
      end
      ARM: begin
        if (bit_en_i) begin
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (bit_en_i) begin
          tx_d      = shift_q[0];
          bit_cnt_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_en_i) begin
          if (bit_last) begin
            if (PARITY_EN != 0) begin
              tx_d    = par_q;
              state_d = PARITY;
            end else begin
              tx_d       = 1'b1;
              stop_cnt_d = 1'b0;
              state_d    = STOP;
            end
          end else begin
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      PARITY: begin
        if (bit_en_i) begin
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = STOP;
        end
      end
      STOP: begin
        if (bit_en_i) begin
          if (stop_last) begin
            // Final stop strobe doubles as an accept slot so frames can abut.
            tx_ready_o = 1'b1;
            done_d     = 1'b1;
            if (tx_valid_i) begin
              shift_d = tx_data_i;
              par_d   = in_par;
              tx_d    = 1'b0;
              state_d = START;
            end else begin
              tx_d    = 1'b1;
              state_d = IDLE;
            end
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (rst_i) tx_ready_o = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      tx_q       <= 1'b1;
      shift_q    <= '0;
      par_q      <= 1'b0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      done_q     <= done_d;
    end
  end

  assign tx_o   = tx_q;
  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;

endmodule
